pixel_scan_sequencer: RTL and testbench

//  Frame-scan controller for the GPU pixel pipeline (stage 0).

---
 rtl/pixel_scan_sequencer.sv | 143 ++++++++++++++
 tb/tb_pixel_scan_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pixel_scan_sequencer.sv
// rtl/pixel_scan_sequencer.sv - frame-scan controller: walks x/y/layer, fetches each layer, emits each pixel
// Optional OPAQUE_SKIP_EN: an opaque layer ack ends the pixel early.
module pixel_scan_sequencer #(
    parameter int H_RES   = 1920,
    parameter int V_RES   = 1080,
    parameter int LAYER_W = 5
) (
    input  logic               pipelineClk,
    input  logic               reset,
    input  logic               enable,
    input  logic [LAYER_W:0]   layerCount,
    output logic               fetchReq,
    input  logic               fetchAck,
    input  logic               opaqueHit,
    output logic [LAYER_W-1:0] fetchLayer,
    output logic [10:0]        fetchX,
    output logic [10:0]        fetchY,
    output logic               pixelValid,
    input  logic               outReady,
    output logic               lineDone,
    output logic               frameDone,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2
    } state_t;

    localparam logic [10:0]        X_LAST     = 11'(H_RES - 1);
    localparam logic [10:0]        Y_LAST     = 11'(V_RES - 1);
    localparam logic [LAYER_W:0]   MAX_LAYERS = {1'b1, {LAYER_W{1'b0}}};
    localparam logic [LAYER_W:0]   ONE_LAYER  = (LAYER_W + 1)'(1);
    localparam logic [LAYER_W-1:0] LAYER_INC  = LAYER_W'(1);

    state_t             state, state_next;
    logic [LAYER_W-1:0] layer, layer_next;
    logic [10:0]        x, x_next;
    logic [10:0]        y, y_next;
    logic [LAYER_W:0]   n_layers, n_layers_next;
    logic               last_layer;
    logic               skip;

    // Zero layers still produces one fetch; anything above the RAM depth saturates.
    function automatic logic [LAYER_W:0] clamp_count(input logic [LAYER_W:0] c);
        if (c == '0)
            return ONE_LAYER;
        if (c > MAX_LAYERS)
            return MAX_LAYERS;
        return c;
    endfunction

`ifdef OPAQUE_SKIP_EN
    assign skip = opaqueHit;
`else
    logic unused_opaque;
    assign unused_opaque = opaqueHit;
    assign skip          = 1'b0;
`endif

    assign last_layer = ({1'b0, layer} == (n_layers - ONE_LAYER));

    always_comb begin
        state_next    = state;
        layer_next    = layer;
        x_next        = x;
        y_next        = y;
        n_layers_next = n_layers;
        lineDone      = 1'b0;
        frameDone     = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    n_layers_next = clamp_count(layerCount);
                    layer_next    = '0;
                    x_next        = '0;
                    y_next        = '0;
                    state_next    = FETCH;
                end
            end
            FETCH: begin
                if (fetchAck) begin
                    if (last_layer || skip)
                        state_next = EMIT;
                    else
                        layer_next = layer + LAYER_INC;
                end
            end
            EMIT: begin
                if (outReady) begin
                    layer_next = '0;
                    if (x != X_LAST) begin
                        x_next     = x + 11'd1;
                        state_next = FETCH;
                    end else begin
                        x_next   = '0;
                        lineDone = 1'b1;
                        if (y != Y_LAST) begin
                            y_next     = y + 11'd1;
                            state_next = FETCH;
                        end else begin
                            // Frame boundary: the only point where enable and layerCount are honoured.
                            y_next    = '0;
                            frameDone = 1'b1;
                            if (enable) begin
                                n_layers_next = clamp_count(layerCount);
                                state_next    = FETCH;
                            end else begin
                                state_next = IDLE;
                            end
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge pipelineClk) begin
        if (reset) begin
            state    <= IDLE;
            layer    <= '0;
            x        <= '0;
            y        <= '0;
            n_layers <= '0;
        end else begin
            state    <= state_next;
            layer    <= layer_next;
            x        <= x_next;
            y        <= y_next;
            n_layers <= n_layers_next;
        end
    end

    assign fetchReq   = (state == FETCH);
    assign pixelValid = (state == EMIT);
    assign busy       = (state != IDLE);
    assign fetchLayer = layer;
    assign fetchX     = x;
    assign fetchY     = y;

endmodule

// File: tb/tb_pixel_scan_sequencer.sv
// tb/tb_pixel_scan_sequencer.sv - directed bench for pixel_scan_sequencer on a 4x2 frame, 2-bit layer index
module tb_pixel_scan_sequencer;

`ifdef OPAQUE_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [2:0]  layerCount;
    logic        fetchReq;
    logic        fetchAck;
    logic        opaqueHit;
    logic [1:0]  fetchLayer;
    logic [10:0] fetchX;
    logic [10:0] fetchY;
    logic        pixelValid;
    logic        outReady;
    logic        lineDone;
    logic        frameDone;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    pixel_scan_sequencer #(.H_RES(4), .V_RES(2), .LAYER_W(2)) dut (
        .pipelineClk(clk),
        .reset(reset),
        .enable(enable),
        .layerCount(layerCount),
        .fetchReq(fetchReq),
        .fetchAck(fetchAck),
        .opaqueHit(opaqueHit),
        .fetchLayer(fetchLayer),
        .fetchX(fetchX),
        .fetchY(fetchY),
        .pixelValid(pixelValid),
        .outReady(outReady),
        .lineDone(lineDone),
        .frameDone(frameDone),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One pixel: n layers, optional ack gap before every ack, optional ready gap, opaque ack on layer opq.
    task automatic run_pixel(input int n, input int p, input int ack_gap, input int rdy_gap, input int opq);
        int nf;
        int px;
        int py;
        px = p % 4;
        py = p / 4;
        nf = (SKIP && opq >= 0 && opq < n) ? opq + 1 : n;
        for (int l = 0; l < nf; l++) begin
            for (int g = 0; g < ack_gap; g++) begin
                fetchAck  = 1'b0;
                opaqueHit = 1'b0;
                #1;
                chk("gap_req",   fetchReq,   1);
                chk("gap_layer", fetchLayer, l);
                chk("gap_x",     fetchX,     px);
                chk("gap_y",     fetchY,     py);
                step();
            end
            fetchAck  = 1'b1;
            opaqueHit = (l == opq);
            #1;
            chk("fetch_req",   fetchReq,   1);
            chk("fetch_busy",  busy,       1);
            chk("fetch_valid", pixelValid, 0);
            chk("fetch_layer", fetchLayer, l);
            chk("fetch_x",     fetchX,     px);
            chk("fetch_y",     fetchY,     py);
            step();
        end
        opaqueHit = 1'b0;
        for (int g = 0; g < rdy_gap; g++) begin
            outReady = 1'b0;
            #1;
            chk("hold_valid", pixelValid, 1);
            chk("hold_req",   fetchReq,   0);
            chk("hold_x",     fetchX,     px);
            chk("hold_y",     fetchY,     py);
            chk("hold_line",  lineDone,   0);
            chk("hold_frame", frameDone,  0);
            step();
        end
        outReady = 1'b1;
        #1;
        chk("emit_valid", pixelValid, 1);
        chk("emit_req",   fetchReq,   0);
        chk("emit_x",     fetchX,     px);
        chk("emit_y",     fetchY,     py);
        chk("emit_line",  lineDone,   px == 3);
        chk("emit_frame", frameDone,  p == 7);
        step();
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        layerCount = 3'd0;
        fetchAck   = 1'b0;
        opaqueHit  = 1'b0;
        outReady   = 1'b0;
        step();
        step();
        chk("rst_busy",  busy,       0);
        chk("rst_req",   fetchReq,   0);
        chk("rst_valid", pixelValid, 0);
        chk("rst_layer", fetchLayer, 0);
        chk("rst_x",     fetchX,     0);
        chk("rst_y",     fetchY,     0);
        chk("rst_line",  lineDone,   0);
        chk("rst_frame", frameDone,  0);

        // Frame 1: three layers, no stalls, ack held high throughout.
        reset      = 1'b0;
        enable     = 1'b1;
        layerCount = 3'd3;
        fetchAck   = 1'b1;
        outReady   = 1'b1;
        #1;
        chk("idle_busy", busy, 0);
        step();
        for (int p = 0; p < 8; p++)
            run_pixel(3, p, 0, 0, -1);

        // Frame 2 starts without an IDLE bubble; a mid-frame layerCount change waits for the boundary.
        for (int p = 0; p < 8; p++) begin
            if (p == 1)
                layerCount = 3'd0;
            run_pixel(3, p, 0, 0, -1);
        end

        // Frame 3: layerCount 0 clamps to one fetch per pixel.
        for (int p = 0; p < 8; p++) begin
            if (p == 1)
                layerCount = 3'd7;
            run_pixel(1, p, 0, 0, -1);
        end

        // Frame 4: layerCount 7 clamps to four; opaque ack, ack gaps and ready backpressure.
        run_pixel(4, 0, 0, 0, 1);
        run_pixel(4, 1, 2, 2, -1);
        layerCount = 3'd2;
        run_pixel(4, 2, 0, 0, -1);
        run_pixel(4, 3, 1, 3, -1);
        for (int p = 4; p < 8; p++)
            run_pixel(4, p, 0, (p == 7) ? 2 : 0, -1);

        // Frame 5: enable drops mid-frame, frame still completes then parks in IDLE.
        for (int p = 0; p < 8; p++) begin
            if (p == 2)
                enable = 1'b0;
            run_pixel(2, p, 0, 0, -1);
        end
        #1;
        chk("stop_busy",  busy,       0);
        chk("stop_req",   fetchReq,   0);
        chk("stop_valid", pixelValid, 0);
        step();
        chk("stop_stay",  busy,       0);

        // Restart, then reset while fetching x=2,y=1 with the fetch outstanding.
        enable = 1'b1;
        #1;
        chk("restart_idle", busy, 0);
        step();
        for (int p = 0; p < 6; p++)
            run_pixel(2, p, 0, 0, -1);
        fetchAck = 1'b0;
        #1;
        chk("pre_rst_req", fetchReq, 1);
        chk("pre_rst_x",   fetchX,   2);
        chk("pre_rst_y",   fetchY,   1);
        reset = 1'b1;
        step();
        chk("abort_busy",  busy,       0);
        chk("abort_req",   fetchReq,   0);
        chk("abort_valid", pixelValid, 0);
        chk("abort_layer", fetchLayer, 0);
        chk("abort_x",     fetchX,     0);
        chk("abort_y",     fetchY,     0);
        chk("abort_line",  lineDone,   0);
        chk("abort_frame", frameDone,  0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
